// File: rtl/gf180mcu_osu_sc_tbus_arbiter.sv
// Round-robin arbiter with break-before-make sequencing for a tinv_1 shared tri-state bus.
// Optional grant timeout enabled by defining TBUS_ARB_TIMEOUT_EN.
module gf180mcu_osu_sc_tbus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned TURN     = 1,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  output logic [N-1:0] GNT,
  output logic [N-1:0] EN,
  output logic [N-1:0] EN_BAR,
  output logic         BUSY,
  output logic         TMO
);

  localparam int unsigned PW = $clog2(N);

  if (N < 2 || N > 16 || TURN < 1 || TURN > 15 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_param
    $error("gf180mcu_osu_sc_tbus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e         state_q;
  logic [PW-1:0]  ptr_q;
  logic [3:0]     cnt_q;
  logic [N-1:0]   gnt_q;
  logic           busy_q;
  logic [PW-1:0]  pick;
  logic [PW-1:0]  ptr_next;
  logic           found;
  logic           hold_req;
  logic [31:0]    idx;

  // First requester at or above ptr_q, wrapping to 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && REQ[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    if (pick == PW'(N - 1)) ptr_next = '0;
    else                    ptr_next = pick + 1'b1;
  end

  // Only the owner's request matters while granted.
  assign hold_req = |(REQ & gnt_q);

`ifdef TBUS_ARB_TIMEOUT_EN
  logic [7:0] hcnt_q;
  logic       tmo_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef TBUS_ARB_TIMEOUT_EN
      hcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
`ifdef TBUS_ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (found) begin
            gnt_q   <= N'(1) << pick;
            ptr_q   <= ptr_next;
            busy_q  <= 1'b1;
            state_q <= StGrant;
`ifdef TBUS_ARB_TIMEOUT_EN
            hcnt_q  <= 8'd1;
`endif
          end
        end
        StGrant: begin
          if (!hold_req) begin
            gnt_q   <= '0;
            cnt_q   <= 4'(TURN);
            state_q <= StTurn;
          end
`ifdef TBUS_ARB_TIMEOUT_EN
          else if (hcnt_q == 8'(HOLD_MAX)) begin
            // Forced release; ptr_q already points past the owner.
            gnt_q   <= '0;
            cnt_q   <= 4'(TURN);
            state_q <= StTurn;
            tmo_q   <= 1'b1;
          end else begin
            hcnt_q  <= hcnt_q + 8'd1;
          end
`endif
        end
        StTurn: begin
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign GNT    = gnt_q;
  assign EN     = gnt_q;
  assign EN_BAR = ~gnt_q;
  assign BUSY   = busy_q;
`ifdef TBUS_ARB_TIMEOUT_EN
  assign TMO    = tmo_q;
`else
  assign TMO    = 1'b0;
`endif

endmodule
